// File: rtl/reg_bank8x16.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank8x16
// Description : Eight-word register bank feeding an 8-to-1 word mux. One
//               synchronous write port plus a sequenced bulk-clear engine
//               that zeroes one word per cycle while BUSY is high.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank8x16 #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [2:0]       WA,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR,
    output logic             BUSY,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7
);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_CLEAR = 1'b1;
    localparam logic [2:0] c_CP_LAST = 3'd7;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [2:0]       r_cp;
    logic [7:0]       w_wr_sel;
    logic [7:0]       w_clr_sel;
    logic [WIDTH-1:0] r_words [8];

    // State register: abort any clear immediately on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: CLR only matters in IDLE; CLEAR always runs to R7.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (CLR) begin
                    w_next_state = c_S_CLEAR;
                end
            end
            c_S_CLEAR: begin
                if (r_cp == c_CP_LAST) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Output decode from registered state only: BUSY and one-hot word selects.
    always_comb begin
        BUSY      = 1'b0;
        w_wr_sel  = 8'h00;
        w_clr_sel = 8'h00;
        case (r_state)
            c_S_IDLE: begin
                if (WE) begin
                    w_wr_sel[WA] = 1'b1;
                end
            end
            c_S_CLEAR: begin
                BUSY            = 1'b1;
                w_clr_sel[r_cp] = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    // Clear pointer: restarts at 0 on a new request, steps once per clear
    // edge and wraps back to 0 after R7 so the next sequence starts clean.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cp <= 3'd0;
        end else if (r_state == c_S_CLEAR) begin
            r_cp <= r_cp + 3'd1;
        end else if (CLR) begin
            r_cp <= 3'd0;
        end
    end

    // Word storage: reset goes to zero rather than CLR_VALUE; the clear
    // engine has priority, though writes are only selected outside CLEAR.
    generate
        for (genvar n = 0; n < 8; n++) begin : g_word
            // Per-word register with clear-over-write priority.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_words[n] <= '0;
                end else if (w_clr_sel[n]) begin
                    r_words[n] <= CLR_VALUE;
                end else if (w_wr_sel[n]) begin
                    r_words[n] <= D;
                end
            end
        end
    endgenerate

    assign Q0 = r_words[0];
    assign Q1 = r_words[1];
    assign Q2 = r_words[2];
    assign Q3 = r_words[3];
    assign Q4 = r_words[4];
    assign Q5 = r_words[5];
    assign Q6 = r_words[6];
    assign Q7 = r_words[7];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank8x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank8x16
// Description : Directed bench for reg_bank8x16 with a per-cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank8x16;

    localparam int unsigned c_W = 16;

    logic           CLK;
    logic           RST_N;
    logic           WE;
    logic [2:0]     WA;
    logic [c_W-1:0] D;
    logic           CLR;
    logic           BUSY;
    logic [c_W-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [c_W-1:0] w_q [8];

    int checks = 0;
    int errors = 0;

    // Expected snapshot per edge: {busy, word7 .. word0}.
    logic [8*c_W:0] sb_q [$];

    // Reference state.
    logic [c_W-1:0] m_words [8];
    logic           m_busy;
    int             m_cp;

    reg_bank8x16 #(.WIDTH(c_W), .CLR_VALUE('0)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA(WA), .D(D), .CLR(CLR),
        .BUSY(BUSY),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
        .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7)
    );

    assign w_q[0] = Q0;
    assign w_q[1] = Q1;
    assign w_q[2] = Q2;
    assign w_q[3] = Q3;
    assign w_q[4] = Q4;
    assign w_q[5] = Q5;
    assign w_q[6] = Q6;
    assign w_q[7] = Q7;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream 8-to-1 mux driven by the bank outputs.
    function automatic logic [c_W-1:0] mux8(input logic [2:0] a);
        return w_q[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_words[i] = '0;
        m_busy = 1'b0;
        m_cp   = 0;
    endtask

    // One clock edge: drive inputs, push the expected post-edge state,
    // then pop and compare it against the DUT just after the edge.
    task automatic step(input logic we, input logic [2:0] wa, input logic [c_W-1:0] d, input logic clr);
        logic [8*c_W:0] exp;
        WE = we; WA = wa; D = d; CLR = clr;
        if (!m_busy) begin
            if (we) m_words[wa] = d;
            if (clr) begin
                m_busy = 1'b1;
                m_cp   = 0;
            end
        end else begin
            m_words[m_cp] = '0;
            if (m_cp == 7) begin
                m_busy = 1'b0;
                m_cp   = 0;
            end else begin
                m_cp++;
            end
        end
        exp[8*c_W] = m_busy;
        for (int i = 0; i < 8; i++) exp[i*c_W +: c_W] = m_words[i];
        sb_q.push_back(exp);
        @(posedge CLK);
        #1;
        exp = sb_q.pop_front();
        check("sb_busy", {15'd0, BUSY}, {15'd0, exp[8*c_W]});
        for (int i = 0; i < 8; i++) check($sformatf("sb_q%0d", i), w_q[i], exp[i*c_W +: c_W]);
        WE = 1'b0; CLR = 1'b0;
    endtask

    task automatic idle_until_not_busy(output int n);
        n = 0;
        while (BUSY && n < 20) begin
            step(1'b0, 3'd0, '0, 1'b0);
            n++;
        end
    endtask

    task automatic async_reset_pulse();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        model_reset();
        check("rst_busy", {15'd0, BUSY}, 16'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_q%0d", i), w_q[i], 16'h0000);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        int n;
        WE = 1'b0; WA = 3'd0; D = '0; CLR = 1'b0;
        RST_N = 1'b0;
        model_reset();
        #12;
        check("por_busy", {15'd0, BUSY}, 16'd0);
        for (int i = 0; i < 8; i++) check($sformatf("por_q%0d", i), w_q[i], 16'h0000);
        @(negedge CLK);
        RST_N = 1'b1;

        // Write sweep; also serves as nonzero preload for the reset test.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0);
            check($sformatf("sweep_q%0d", i), w_q[i], 16'h1000 + 16'(i));
        end
        check("mux_a5", mux8(3'd5), 16'h1005);

        // Asynchronous reset between edges.
        async_reset_pulse();

        // Clear sequence from an all-ones fill.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'hFFFF, 1'b0);
        step(1'b0, 3'd0, '0, 1'b1);
        check("clr_busy_rise", {15'd0, BUSY}, 16'd1);
        idle_until_not_busy(n);
        check("clr_busy_len", 16'(n), 16'd8);
        for (int i = 0; i < 8; i++) check($sformatf("clr_done_q%0d", i), w_q[i], 16'h0000);

        // Write during clear cycle 3 is dropped.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'hFFFF, 1'b0);
        step(1'b0, 3'd0, '0, 1'b1);
        step(1'b0, 3'd0, '0, 1'b0);
        step(1'b0, 3'd0, '0, 1'b0);
        step(1'b1, 3'd7, 16'hABCD, 1'b0);
        idle_until_not_busy(n);
        check("wdc_busy_len", 16'(n + 3), 16'd8);
        check("wdc_q7_dropped", Q7, 16'h0000);
        step(1'b1, 3'd7, 16'hABCD, 1'b0);
        check("wdc_q7_after", Q7, 16'hABCD);

        // Simultaneous write and clear request in IDLE.
        step(1'b1, 3'd2, 16'h5A5A, 1'b1);
        check("sim_q2_busy1", Q2, 16'h5A5A);
        step(1'b0, 3'd0, '0, 1'b0);
        step(1'b0, 3'd0, '0, 1'b0);
        check("sim_q2_busy3", Q2, 16'h5A5A);
        step(1'b0, 3'd0, '0, 1'b0);
        check("sim_q2_cleared", Q2, 16'h0000);
        idle_until_not_busy(n);
        check("sim_busy_len", 16'(n + 3), 16'd8);

        // Reset in the middle of a clear.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'h00F0 + 16'(i), 1'b0);
        step(1'b0, 3'd0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, '0, 1'b0);
        check("mid_q5_before", Q5, 16'h00F5);
        async_reset_pulse();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd0, '0, 1'b0);
            check("mid_no_resume", {15'd0, BUSY}, 16'd0);
        end
        step(1'b1, 3'd0, 16'h1234, 1'b0);
        check("mid_first_write", Q0, 16'h1234);

        // Back-to-back: CLR held high gives 8 busy cycles then one idle.
        step(1'b0, 3'd0, '0, 1'b1);
        n = 1;
        while (BUSY && n < 20) begin
            step(1'b0, 3'd0, '0, 1'b1);
            if (BUSY) n++;
        end
        check("b2b_busy_len", 16'(n), 16'd8);
        check("b2b_idle", {15'd0, BUSY}, 16'd0);
        step(1'b0, 3'd0, '0, 1'b1);
        check("b2b_restart", {15'd0, BUSY}, 16'd1);
        idle_until_not_busy(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
